// File: rtl/m_ext_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : m_ext_unit_if
// Brief    : Execute-to-writeback handshake bundle for the RV32M unit.
// Revision : 1.0
// ============================================================================
interface m_ext_unit_if #(
    parameter int XLEN = 32
);
    logic            exe2mul_req_i;
    logic [2:0]      exe2mul_op_i;
    logic [XLEN-1:0] exe2mul_rs1_i;
    logic [XLEN-1:0] exe2mul_rs2_i;
    logic            exe2mul_kill_i;
    logic [XLEN-1:0] mul2wrb_alu_m_result_o;
    logic            mul2wrb_alu_m_res_o;
    logic            mul2fwd_busy_o;

    modport master (
        output exe2mul_req_i, exe2mul_op_i, exe2mul_rs1_i, exe2mul_rs2_i, exe2mul_kill_i,
        input  mul2wrb_alu_m_result_o, mul2wrb_alu_m_res_o, mul2fwd_busy_o
    );

    modport slave (
        input  exe2mul_req_i, exe2mul_op_i, exe2mul_rs1_i, exe2mul_rs2_i, exe2mul_kill_i,
        output mul2wrb_alu_m_result_o, mul2wrb_alu_m_res_o, mul2fwd_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/m_ext_unit.sv
`default_nettype none
// ============================================================================
// Module   : m_ext_unit
// Brief    : RV32M execute unit: two-cycle multiply, radix-2 restoring divide.
// Revision : 1.0
// ============================================================================
module m_ext_unit #(
    parameter int XLEN = 32
) (
    input wire          clk,
    input wire          rst_n,
    m_ext_unit_if.slave bus
);
    localparam int         c_CNT_W       = $clog2(XLEN);
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_MUL      = 3'd1;
    localparam logic [2:0] c_ST_DIV_ITER = 3'd2;
    localparam logic [2:0] c_ST_FIX      = 3'd3;
    localparam logic [2:0] c_ST_DONE     = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_accept;
    logic              w_div_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN:0]     w_sh;
    logic [XLEN:0]     w_diff;
    logic              w_fit;
    logic [XLEN-1:0]   w_fix_res;

    // Request decode; absolute values only apply to signed DIV/REM
    assign w_accept      = (r_state == c_ST_IDLE) & bus.exe2mul_req_i & ~bus.exe2mul_kill_i;
    assign w_div_signed  = bus.exe2mul_op_i[2] & ~bus.exe2mul_op_i[0];
    assign w_a_neg       = w_div_signed & bus.exe2mul_rs1_i[XLEN-1];
    assign w_b_neg       = w_div_signed & bus.exe2mul_rs2_i[XLEN-1];
    assign w_a_abs       = w_a_neg ? -bus.exe2mul_rs1_i : bus.exe2mul_rs1_i;
    assign w_b_abs       = w_b_neg ? -bus.exe2mul_rs2_i : bus.exe2mul_rs2_i;
    assign w_div_zero    = (bus.exe2mul_rs2_i == '0);
    assign w_ovf         = w_div_signed & (bus.exe2mul_rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                           & (&bus.exe2mul_rs2_i);
    assign w_special     = w_div_zero | w_ovf;
    assign w_special_res = bus.exe2mul_op_i[1] ? (w_div_zero ? bus.exe2mul_rs1_i : '0)
                                               : (w_div_zero ? '1 : bus.exe2mul_rs1_i);

    // Multiply of sign/zero-extended operands, kept modulo 2^(2*XLEN)
    assign w_sign_a  = ~(r_op[1] & r_op[0]) & r_opa[XLEN-1];
    assign w_sign_b  = ~r_op[1] & r_opb[XLEN-1];
    assign w_prod    = {{XLEN{w_sign_a}}, r_opa} * {{XLEN{w_sign_b}}, r_opb};
    assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // One restoring step; the extra bit covers divisors with the MSB set
    assign w_sh   = {r_rem, r_opa[XLEN-1]};
    assign w_diff = w_sh - {1'b0, r_opb};
    assign w_fit  = ~w_diff[XLEN];

    assign w_fix_res = r_op[1] ? (r_neg_r ? -r_rem : r_rem)
                               : (r_neg_q ? -r_opa : r_opa);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (!bus.exe2mul_op_i[2]) w_next = c_ST_MUL;
                    else if (w_special)       w_next = c_ST_DONE;
                    else                      w_next = c_ST_DIV_ITER;
                end
            end
            c_ST_MUL:      w_next = bus.exe2mul_kill_i ? c_ST_IDLE : c_ST_DONE;
            c_ST_DIV_ITER: begin
                if (bus.exe2mul_kill_i)     w_next = c_ST_IDLE;
                else if (r_cnt == '0)       w_next = c_ST_FIX;
            end
            c_ST_FIX:      w_next = bus.exe2mul_kill_i ? c_ST_IDLE : c_ST_DONE;
            default:       w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= bus.exe2mul_op_i[1:0];
                r_opa   <= w_a_abs;
                r_opb   <= w_b_abs;
                r_rem   <= '0;
                r_cnt   <= c_CNT_W'(XLEN-1);
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end else if (r_state == c_ST_DIV_ITER) begin
                r_rem <= w_fit ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
                r_opa <= {r_opa[XLEN-2:0], w_fit};
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            // Result only moves on entry to DONE, so a kill leaves it intact
            if (w_next == c_ST_DONE) begin
                case (r_state)
                    c_ST_IDLE: r_result <= w_special_res;
                    c_ST_MUL:  r_result <= w_mul_res;
                    c_ST_FIX:  r_result <= w_fix_res;
                    default:   r_result <= r_result;
                endcase
            end
        end
    end

    assign bus.mul2wrb_alu_m_result_o = r_result;
    assign bus.mul2wrb_alu_m_res_o    = (r_state == c_ST_DONE);
    assign bus.mul2fwd_busy_o         = (r_state == c_ST_MUL) | (r_state == c_ST_DIV_ITER)
                                        | (r_state == c_ST_FIX);
endmodule
`default_nettype wire

// File: tb/tb_m_ext_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_ext_unit
// Brief    : Directed bench for m_ext_unit with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_m_ext_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_busy = 0;

    m_ext_unit_if #(.XLEN(32)) bus ();

    m_ext_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the RV32M rules
    function automatic logic [31:0] f_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        int              ia, ib;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000:  begin p = sa * sb; return p[31:0]; end
            3'b001:  begin p = sa * sb; return p[63:32]; end
            3'b010:  begin p = sa * longint'(ub); return p[63:32]; end
            3'b011:  begin up = ua * ub; return up[63:32]; end
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from acceptance to the writeback pulse
    function automatic int f_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 2;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Model: m_d is the index of the current cycle after the acceptance edge
    bit          m_active;
    int          m_d, m_lat;
    logic [31:0] m_exp, m_result;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_d      <= 0;
            m_lat    <= 0;
            m_exp    <= '0;
            m_result <= '0;
        end else if (!m_active) begin
            if (bus.exe2mul_req_i && !bus.exe2mul_kill_i) begin
                m_active <= 1'b1;
                m_d      <= 0;
                m_lat    <= f_lat(bus.exe2mul_op_i, bus.exe2mul_rs1_i, bus.exe2mul_rs2_i);
                m_exp    <= f_calc(bus.exe2mul_op_i, bus.exe2mul_rs1_i, bus.exe2mul_rs2_i);
                if (f_lat(bus.exe2mul_op_i, bus.exe2mul_rs1_i, bus.exe2mul_rs2_i) == 1)
                    m_result <= f_calc(bus.exe2mul_op_i, bus.exe2mul_rs1_i, bus.exe2mul_rs2_i);
            end
        end else if (m_d < m_lat - 1) begin
            if (bus.exe2mul_kill_i) begin
                m_active <= 1'b0;
            end else begin
                m_d <= m_d + 1;
                if (m_d + 1 == m_lat - 1) m_result <= m_exp;
            end
        end else begin
            m_active <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every cycle: advance to the falling edge and compare against the model
    task automatic tick();
        @(negedge clk);
        chk("busy", {31'd0, bus.mul2fwd_busy_o}, {31'd0, m_active && (m_d < m_lat - 1)});
        chk("res", {31'd0, bus.mul2wrb_alu_m_res_o}, {31'd0, m_active && (m_d == m_lat - 1)});
        chk("result", bus.mul2wrb_alu_m_result_o, m_result);
        if (bus.mul2fwd_busy_o) n_busy++;
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int t;
        bit seen;
        t    = 0;
        seen = 1'b0;
        n_busy = 0;
        bus.exe2mul_req_i = 1'b1;
        bus.exe2mul_op_i  = op;
        bus.exe2mul_rs1_i = a;
        bus.exe2mul_rs2_i = b;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            t++;
            if (bus.mul2fwd_busy_o || bus.mul2wrb_alu_m_res_o) bus.exe2mul_req_i = 1'b0;
            if (bus.mul2wrb_alu_m_res_o) seen = 1'b1;
        end
        bus.exe2mul_req_i = 1'b0;
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no result pulse within 60 cycles", name);
        end else begin
            chk({name, "_value"}, bus.mul2wrb_alu_m_result_o, exp_res);
            chk({name, "_latency"}, 32'(t), 32'(exp_lat));
            chk({name, "_busy"}, 32'(n_busy), 32'(exp_lat - 1));
        end
        tick();
    endtask

    initial begin
        int res_cnt;
        bus.exe2mul_req_i  = 1'b0;
        bus.exe2mul_op_i   = 3'd0;
        bus.exe2mul_rs1_i  = '0;
        bus.exe2mul_rs2_i  = '0;
        bus.exe2mul_kill_i = 1'b0;
        tick();
        tick();
        chk("rst_result", bus.mul2wrb_alu_m_result_o, 32'd0);
        chk("rst_res", {31'd0, bus.mul2wrb_alu_m_res_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.mul2fwd_busy_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        do_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2);
        do_op("mul_neg",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        do_op("div_7_m2",   3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        do_op("rem_7_m2",   3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        do_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        34);
        do_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         34);
        do_op("divu_big",   3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 34);
        do_op("remu_big",   3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);
        do_op("divu_by0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("remu_by0",   3'b111, 32'd5,         32'd0,         32'd5,         1);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Kill in the tenth DIV_ITER cycle; prior result must survive
        bus.exe2mul_req_i = 1'b1;
        bus.exe2mul_op_i  = 3'b101;
        bus.exe2mul_rs1_i = 32'd1000;
        bus.exe2mul_rs2_i = 32'd3;
        for (int i = 0; i < 5 && !bus.mul2fwd_busy_o; i++) tick();
        bus.exe2mul_req_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.exe2mul_kill_i = 1'b1;
        tick();
        bus.exe2mul_kill_i = 1'b0;
        chk("kill_busy", {31'd0, bus.mul2fwd_busy_o}, 32'd0);
        chk("kill_hold", bus.mul2wrb_alu_m_result_o, 32'h8000_0000);
        for (int i = 0; i < 30; i++) tick();
        do_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 2);

        // Asynchronous reset in the middle of a divide
        bus.exe2mul_req_i = 1'b1;
        bus.exe2mul_op_i  = 3'b100;
        bus.exe2mul_rs1_i = 32'd12345;
        bus.exe2mul_rs2_i = 32'd17;
        tick();
        bus.exe2mul_req_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_result", bus.mul2wrb_alu_m_result_o, 32'd0);
        chk("arst_res", {31'd0, bus.mul2wrb_alu_m_res_o}, 32'd0);
        chk("arst_busy", {31'd0, bus.mul2fwd_busy_o}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Request held high: IDLE/MUL/DONE repeats, one pulse per acceptance
        res_cnt = 0;
        bus.exe2mul_req_i = 1'b1;
        bus.exe2mul_op_i  = 3'b011;
        bus.exe2mul_rs1_i = 32'hFFFF_FFFF;
        bus.exe2mul_rs2_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.mul2wrb_alu_m_res_o) res_cnt++;
        end
        bus.exe2mul_req_i = 1'b0;
        chk("held_req_pulses", 32'(res_cnt), 32'd4);
        chk("held_req_value", bus.mul2wrb_alu_m_result_o, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/m_ext_unit.md
# m_ext_unit

RV32M execute unit that produces the multiply/divide result consumed by the writeback stage on the mul2wrb interface. It accepts one M-extension operation at a time from the execute stage, computes multiplies in a fixed two-cycle path and divides/remainders with a radix-2 restoring iterative divider. Results are presented to writeback as a one-cycle valid pulse. A busy flag stalls the pipeline while an operation is in flight.

## Interface
- XLEN, default 32: operand and result width.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- exe2mul_req_i  input  1  operation request, sampled only in IDLE.
- exe2mul_op_i  input  3  operation = funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- exe2mul_rs1_i  input  XLEN  operand A (dividend / multiplicand).
- exe2mul_rs2_i  input  XLEN  operand B (divisor / multiplier).
- exe2mul_kill_i  input  1  pipeline flush; aborts any in-flight operation.
- mul2wrb_alu_m_result_o  output  XLEN  result; registered.
- mul2wrb_alu_m_res_o  output  1  result valid, one-cycle pulse.
- mul2fwd_busy_o  output  1  operation in flight; pipeline stall request.

## Operation
- States: IDLE, MUL, DIV_ITER, FIX, DONE.
- IDLE: req=1 and kill=0 latches op and operands, then:
  - MUL ops go to MUL.
  - DIV/REM with divisor 0 or signed overflow go directly to DONE with the special result loaded.
  - Other DIV/REM go to DIV_ITER with counter = XLEN-1.
  - req=1 with kill=1: not accepted.
- MUL: forms the 2*XLEN product of sign/zero-extended operands.
  - MUL: A, B signed; low XLEN bits.
  - MULH: A, B signed; high XLEN bits.
  - MULHSU: A signed, B unsigned; high XLEN bits.
  - MULHU: A, B unsigned; high XLEN bits.
  - Result register loaded; next state DONE.
- DIV_ITER: operates on absolute values (signed ops) or raw values (unsigned ops).
  - Each cycle: shift remainder:quotient left one bit; trial-subtract divisor; on non-negative difference keep it and set quotient LSB=1.
  - Counter decrements; at counter=0 go to FIX.
- FIX: signed ops only:
  - Negate quotient if dividend and divisor signs differ.
  - Negate remainder if dividend negative.
  - Load quotient (DIV/DIVU) or remainder (REM/REMU) into result; next state DONE.
- DONE: res_o=1 for exactly one cycle; next state IDLE. A req presented during DONE is ignored; it must be re-presented in IDLE.
- Special results:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = A.
  - DIV with A = 0x80000000 and B = 0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- kill=1 in MUL, DIV_ITER or FIX: next state IDLE, no res pulse, result register unchanged. kill in DONE does not suppress the pulse already asserted.
- mul2wrb_alu_m_result_o changes only on entry to DONE and holds its value otherwise.
- All arithmetic is modulo 2^XLEN except the internal 2*XLEN product.

## Timing
- Reset: state IDLE; result 0; res_o 0; busy_o 0; counter 0.
- busy_o = 1 in MUL, DIV_ITER, FIX; 0 in IDLE and DONE. Decoded from state, so it is valid in the cycle after acceptance.
- The requester holds req and operands until busy_o is seen; it does not re-request in the acceptance cycle (T+1 is non-IDLE).
- Latency, with the request accepted on edge T:
  - MUL ops: DONE in cycle T+2 (result valid in the cycle after edge T+2).
  - Special-case divide: DONE in cycle T+1.
  - Normal divide: XLEN DIV_ITER cycles (T+1..T+32), FIX at T+33, DONE at T+34.
- Throughput: one operation per latency+1 cycles (the IDLE cycle is mandatory).
- Reset asserted mid-operation forces IDLE immediately (asynchronous); no res pulse follows.

## Test plan
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> result 0x00000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0x00000002 -> result 0xFFFFFFFF.
- All MUL ops: res_o pulses exactly at T+2 and busy_o is high only in cycle T+1.
- DIV -7 / 2 -> 0xFFFFFFFD.
- REM -7 / 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14.
- REMU 100 / 7 -> 2.
- Each normal divide: res_o at T+34 and busy_o high for 33 cycles.
- DIVU 5 / 0 -> 0xFFFFFFFF at T+1.
- REM 0x80000000 / 0xFFFFFFFF -> 0.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- Kill during DIV_ITER cycle 10 -> IDLE next cycle, no res pulse, result holds its prior value. A new MUL 3 × 4 issued afterwards -> 12.
- rst_n low mid-divide: outputs zero immediately. Release, then req held high throughout: accepted only in IDLE, exactly one res pulse per accepted request.
